microwave_timer_fsm: RTL and testbench

Single-clock, parametrised microwave-oven controller. Loads a cook time and power level, counts down in prescaled time units, and drives the magnetron enable with a power-level duty cycle. Adds a door-interlock pause/resume, cancel, add-time while running, and a one-cycle completion pulse. Sits between the front-panel input logic and the magnetron/lamp drivers.

---
 rtl/microwave_timer_fsm_if.sv | 28 ++
 rtl/microwave_timer_fsm.sv | 116 +++++++++++
 tb/tb_microwave_timer_fsm.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/microwave_timer_fsm_if.sv
// Front-panel / driver-side signal bundle for the microwave timer controller.
// start/stop/door_open are plain levels sampled on every rising clk edge; there is
// no ready return path, so acceptance is observed through state/busy on later cycles.
interface microwave_timer_fsm_if #(
   parameter int TW = 8,
   parameter int PW = 2
);
   logic          start;
   logic          stop;
   logic          door_open;
   logic [TW-1:0] tin;
   logic [PW-1:0] pwr;
   logic          p;
   logic          busy;
   logic          done;
   logic [TW-1:0] remain;
   logic [1:0]    state;

   modport master (
      output start, stop, door_open, tin, pwr,
      input  p, busy, done, remain, state
   );

   modport slave (
      input  start, stop, door_open, tin, pwr,
      output p, busy, done, remain, state
   );
endinterface

// File: rtl/microwave_timer_fsm.sv
// Microwave cook-time controller: prescaled countdown, power-level duty cycle on the
// magnetron enable, door pause/resume, cancel, add-time and a one-cycle done pulse.
module microwave_timer_fsm #(
   parameter int TW    = 8,
   parameter int PW    = 2,
   parameter int PRESC = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   microwave_timer_fsm_if.slave    bus
);
   localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [CW-1:0] PMAX = CW'(PRESC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t        st, n_st;
   logic [TW-1:0] rem, n_rem;
   logic [CW-1:0] pre, n_pre;
   logic [PW-1:0] dph, n_dph;
   logic [PW-1:0] pwr_lat, n_pwr;
   logic          p_q, busy_q, done_q;
   logic          n_p, n_busy, n_done;
   logic          expiry;
   logic [TW:0]   sum;

   assign expiry = (pre == PMAX);
   assign sum    = {1'b0, rem} + {1'b0, bus.tin};

   always_comb begin
      n_st  = st;
      n_rem = rem;
      n_pre = pre;
      n_dph = dph;
      n_pwr = pwr_lat;
      unique case (st)
         IDLE: begin
            if (!bus.stop && !bus.door_open && bus.start && (bus.tin != '0)) begin
               n_st  = RUN;
               n_rem = bus.tin;
               n_pwr = bus.pwr;
               n_pre = '0;
               n_dph = '0;
            end
         end
         RUN: begin
            if (bus.stop) begin
               n_st  = IDLE;
               n_rem = '0;
               n_pre = '0;
               n_dph = '0;
            end else if (bus.door_open) begin
               n_st = PAUSE;
            end else if (expiry) begin
               // A start landing on a unit boundary is dropped; expiry wins.
               n_pre = '0;
               n_dph = dph + PW'(1);
               n_rem = rem - TW'(1);
               if (rem == TW'(1)) n_st = DONE;
            end else begin
               n_pre = pre + CW'(1);
               if (bus.start) n_rem = sum[TW] ? '1 : sum[TW-1:0];
            end
         end
         PAUSE: begin
            if (bus.stop) begin
               n_st  = IDLE;
               n_rem = '0;
               n_pre = '0;
               n_dph = '0;
            end else if (bus.start && !bus.door_open) begin
               n_st = RUN;
            end
         end
         DONE: n_st = IDLE;
         default: n_st = IDLE;
      endcase
      // Outputs are registered from the next-state values so they line up with state.
      n_p    = (n_st == RUN) && (n_dph <= n_pwr);
      n_busy = (n_st == RUN) || (n_st == PAUSE);
      n_done = (n_st == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st      <= IDLE;
         rem     <= '0;
         pre     <= '0;
         dph     <= '0;
         pwr_lat <= '0;
         p_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         st      <= n_st;
         rem     <= n_rem;
         pre     <= n_pre;
         dph     <= n_dph;
         pwr_lat <= n_pwr;
         p_q     <= n_p;
         busy_q  <= n_busy;
         done_q  <= n_done;
      end
   end

   assign bus.p      = p_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.remain = rem;
   assign bus.state  = st;
endmodule

// File: tb/tb_microwave_timer_fsm.sv
// Self-checking bench for microwave_timer_fsm: a vector table fed through an expected
// queue, then hand-written sequences for duty cycle, pause/resume, add-time and reset.
module tb_microwave_timer_fsm;
   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_DONE  = 2'b11;
   localparam int W = 13;

   logic clk;
   logic rst;
   microwave_timer_fsm_if #(.TW(8), .PW(2)) bus ();

   microwave_timer_fsm #(.TW(8), .PW(2), .PRESC(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       start;
      logic       stop;
      logic       door;
      logic [7:0] tin;
      logic [1:0] pwr;
      logic [1:0] st;
      logic [7:0] rem;
      logic       p;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t           vecs[$];
   logic [W-1:0]   exp_q[$];
   int             n_checks = 0;
   int             n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] obs();
      return {bus.state, bus.remain, bus.p, bus.busy, bus.done};
   endfunction

   function automatic void add(input logic s, sp, d, input logic [7:0] t, input logic [1:0] pw,
                               input logic [1:0] es, input logic [7:0] er,
                               input logic ep, eb, ed);
      vec_t v;
      v.start = s; v.stop = sp; v.door = d; v.tin = t; v.pwr = pw;
      v.st = es; v.rem = er; v.p = ep; v.busy = eb; v.done = ed;
      vecs.push_back(v);
   endfunction

   task automatic drive(input logic s, sp, d, input logic [7:0] t, input logic [1:0] pw);
      bus.start = s; bus.stop = sp; bus.door_open = d; bus.tin = t; bus.pwr = pw;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, want);
      end
   endtask

   int run, phigh, exp_p;
   logic [W-1:0] want, got;

   initial begin
      // Table: normal full-power cook, start ignored in DONE, corner cases, pause/stop.
      add(1, 0, 0, 8'd3, 2'd3, S_RUN, 8'd3, 1, 1, 0);
      for (int k = 1; k <= 11; k++) add(0, 0, 0, 8'd0, 2'd0, S_RUN, 8'(3 - k / 4), 1, 1, 0);
      add(0, 0, 0, 8'd0, 2'd0, S_DONE, 8'd0, 0, 0, 1);
      add(1, 0, 0, 8'd3, 2'd3, S_IDLE, 8'd0, 0, 0, 0);
      add(0, 0, 0, 8'd0, 2'd0, S_IDLE, 8'd0, 0, 0, 0);
      add(1, 0, 0, 8'd5, 2'd0, S_RUN, 8'd5, 1, 1, 0);
      add(1, 1, 0, 8'd7, 2'd0, S_IDLE, 8'd0, 0, 0, 0);
      add(1, 0, 0, 8'd0, 2'd2, S_IDLE, 8'd0, 0, 0, 0);
      add(1, 0, 1, 8'd9, 2'd3, S_IDLE, 8'd0, 0, 0, 0);
      add(0, 1, 0, 8'd0, 2'd0, S_IDLE, 8'd0, 0, 0, 0);
      add(1, 0, 0, 8'd4, 2'd2, S_RUN, 8'd4, 1, 1, 0);
      add(0, 0, 1, 8'd0, 2'd0, S_PAUSE, 8'd4, 0, 1, 0);
      add(1, 0, 1, 8'd0, 2'd0, S_PAUSE, 8'd4, 0, 1, 0);
      add(0, 1, 1, 8'd0, 2'd0, S_IDLE, 8'd0, 0, 0, 0);

      // Clock/reset: reset outputs must appear without any clock edge.
      drive(0, 0, 0, 8'd0, 2'd0);
      rst = 1'b1;
      #2;
      chk("reset_outputs", int'(obs()), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc();
      chk("idle_after_reset", int'(obs()), 0);

      foreach (vecs[i]) begin
         drive(vecs[i].start, vecs[i].stop, vecs[i].door, vecs[i].tin, vecs[i].pwr);
         exp_q.push_back({vecs[i].st, vecs[i].rem, vecs[i].p, vecs[i].busy, vecs[i].done});
         cyc();
         want = exp_q.pop_front();
         got  = obs();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL vec%0d: got st=%0d rem=%0d p=%0b busy=%0b done=%0b expected st=%0d rem=%0d p=%0b busy=%0b done=%0b",
                     i, got[12:11], got[10:3], got[2], got[1], got[0],
                     want[12:11], want[10:3], want[2], want[1], want[0]);
         end
      end
      drive(0, 0, 0, 8'd0, 2'd0);
      cyc();

      // Duty cycle at pwr=1: p high in units 1-2 and 5-6 of an 8-unit cook.
      drive(1, 0, 0, 8'd8, 2'd1);
      cyc();
      drive(0, 0, 0, 8'd0, 2'd0);
      run = 0;
      phigh = 0;
      while (bus.state == S_RUN && run < 100) begin
         run++;
         exp_p = (((run - 1) / 4) % 4) <= 1 ? 1 : 0;
         chk($sformatf("duty_p_cycle%0d", run), int'(bus.p), exp_p);
         phigh += int'(bus.p);
         cyc();
      end
      chk("duty_run_cycles", run, 32);
      chk("duty_p_high", phigh, 16);
      chk("duty_done", int'(bus.done), 1);
      cyc();

      // Door opened during RUN cycle 6; the pause edge itself does not count.
      drive(1, 0, 0, 8'd3, 2'd3);
      cyc();
      drive(0, 0, 0, 8'd0, 2'd0);
      repeat (5) cyc();
      drive(0, 0, 1, 8'd0, 2'd0);
      cyc();
      chk("pause_state", int'(bus.state), int'(S_PAUSE));
      chk("pause_p", int'(bus.p), 0);
      chk("pause_remain", int'(bus.remain), 2);
      chk("pause_busy", int'(bus.busy), 1);
      repeat (9) cyc();
      chk("pause_hold_state", int'(bus.state), int'(S_PAUSE));
      chk("pause_hold_remain", int'(bus.remain), 2);
      drive(1, 0, 0, 8'd3, 2'd0);
      cyc();
      drive(0, 0, 0, 8'd0, 2'd0);
      chk("resume_remain", int'(bus.remain), 2);
      run = 0;
      while (bus.state == S_RUN && run < 50) begin
         run++;
         cyc();
      end
      chk("resume_run_cycles", run, 7);
      chk("resume_done", int'(bus.done), 1);
      cyc();

      // Add-time: saturation, plain add, and a start dropped on a unit expiry.
      drive(1, 0, 0, 8'd250, 2'd2);
      cyc();
      drive(1, 0, 0, 8'd10, 2'd2);
      cyc();
      chk("add_saturate", int'(bus.remain), 255);
      cyc();
      chk("add_saturate_again", int'(bus.remain), 255);
      drive(0, 1, 0, 8'd0, 2'd0);
      cyc();
      chk("add_stop_remain", int'(bus.remain), 0);
      drive(1, 0, 0, 8'd5, 2'd2);
      cyc();
      drive(1, 0, 0, 8'd2, 2'd2);
      cyc();
      chk("add_plain", int'(bus.remain), 7);
      drive(0, 0, 0, 8'd0, 2'd0);
      cyc();
      cyc();
      drive(1, 0, 0, 8'd9, 2'd2);
      cyc();
      drive(0, 0, 0, 8'd0, 2'd0);
      chk("add_on_expiry_dropped", int'(bus.remain), 6);
      drive(0, 1, 0, 8'd0, 2'd0);
      cyc();
      drive(0, 0, 0, 8'd0, 2'd0);

      // Asynchronous reset mid-RUN, then a fresh one-unit cook.
      drive(1, 0, 0, 8'd5, 2'd3);
      cyc();
      drive(0, 0, 0, 8'd0, 2'd0);
      chk("pre_reset_remain", int'(bus.remain), 5);
      #3;
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", int'(obs()), 0);
      #2;
      rst = 1'b0;
      cyc();
      chk("after_reset_idle", int'(obs()), 0);
      drive(1, 0, 0, 8'd1, 2'd3);
      cyc();
      drive(0, 0, 0, 8'd0, 2'd0);
      run = 0;
      while (bus.state == S_RUN && run < 20) begin
         run++;
         cyc();
      end
      chk("one_unit_run_cycles", run, 4);
      chk("one_unit_done", int'(bus.done), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
